// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks DEPTH in-flight instructions after ID (0 = EX ...
// DEPTH-1 = WB), detects read-after-write hazards for the instruction in ID,
// produces the stall/bubble request, the EX operand forwarding selects and a
// saturating count of stalled cycles.
//
// Build option:
//   HAZARD_SCOREBOARD_FWD_EN defined   - forwarding pipeline; only load-use
//                                        (producer load in EX) stalls, and
//                                        fwd_sel_1/2 pick the youngest producer.
//   HAZARD_SCOREBOARD_FWD_EN undefined - no forwarding; any in-flight producer
//                                        stalls, fwd_sel_1/2 are tied to 0.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   enable               pipeline advance; low freezes entries and counter
//   id_valid             ID holds a real instruction
//   id_rs1/2, id_use_*   ID source registers and their read enables
//   id_rd, id_reg_write, id_mem_read   ID destination and control bits
//   flush                branch taken in stage FLUSH_STAGE
//   stall                combinational: hold IF/ID, bubble into EX
//   fwd_sel_1/2          combinational EX operand source (0 = regfile, k = stage k)
//   stall_count          registered saturating stalled-cycle count
module hazard_scoreboard #(
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned FLUSH_STAGE = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic [2:0]            fwd_sel_1,
    output logic [2:0]            fwd_sel_2,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    entry_t id_ent;
    logic   hazard;
    logic   unused_bits;

    // An entry produces r when it will write a non-zero destination equal to r.
    function automatic logic produces(input entry_t e, input logic [REG_ADDR_W-1:0] r);
        return e.valid && e.reg_write && (e.rd == r) && (e.rd != '0);
    endfunction

    // Pack the ID fields into an entry.
    always_comb begin
        id_ent           = '0;
        id_ent.valid     = 1'b1;
        id_ent.rd        = id_rd;
        id_ent.reg_write = id_reg_write;
        id_ent.mem_read  = id_mem_read;
        id_ent.rs1       = id_rs1;
        id_ent.rs2       = id_rs2;
        id_ent.use_rs1   = id_use_rs1;
        id_ent.use_rs2   = id_use_rs2;
    end

    // Hazard detection against the policy's stage set.
    always_comb begin
        hazard = 1'b0;
`ifdef HAZARD_SCOREBOARD_FWD_EN
        // Only a load sitting in EX cannot be forwarded in time.
        if (id_valid && ent_q[0].mem_read) begin
            if (id_use_rs1 && produces(ent_q[0], id_rs1)) hazard = 1'b1;
            if (id_use_rs2 && produces(ent_q[0], id_rs2)) hazard = 1'b1;
        end
`else
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (id_valid) begin
                if (id_use_rs1 && produces(ent_q[i], id_rs1)) hazard = 1'b1;
                if (id_use_rs2 && produces(ent_q[i], id_rs2)) hazard = 1'b1;
            end
        end
`endif
    end

    // A flush squashes the ID instruction anyway, so it overrides the stall.
    assign stall = hazard && !flush;

    // Forward select: scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_sel_1 = 3'd0;
        fwd_sel_2 = 3'd0;
`ifdef HAZARD_SCOREBOARD_FWD_EN
        for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
            if (ent_q[0].valid && ent_q[0].use_rs1 && produces(ent_q[k], ent_q[0].rs1))
                fwd_sel_1 = 3'(k);
            if (ent_q[0].valid && ent_q[0].use_rs2 && produces(ent_q[k], ent_q[0].rs2))
                fwd_sel_2 = 3'(k);
        end
`endif
    end

    // Next pipeline contents: shift, insert ID or a bubble, squash on flush.
    always_comb begin
        ent_d[0] = (id_valid && !stall && !flush) ? id_ent : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i-1];
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i <= FLUSH_STAGE) ent_d[i] = '0;
            end
        end
    end

    // Pipeline entries and stall counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ent_q       <= '{default: '0};
            stall_count <= '0;
        end else if (enable) begin
            ent_q <= ent_d;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    // Not every stored field is consumed in every build/stage.
    always_comb begin
        unused_bits = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            unused_bits = unused_bits ^ (^ent_q[i]);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH = 3, FLUSH_STAGE = 1).
// A second instance with CNT_W = 2 shares all inputs to observe saturation.
// Expectations follow whichever hazard policy HAZARD_SCOREBOARD_FWD_EN selects.
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam int STALLS_PER = 1;
    localparam int LINKS      = 5;
`else
    localparam int STALLS_PER = 3;
    localparam int LINKS      = 2;
`endif

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic        stall;
    logic [2:0]  fwd_sel_1;
    logic [2:0]  fwd_sel_2;
    logic [31:0] stall_count;
    logic        sat_stall;
    logic [2:0]  sat_fwd_1;
    logic [2:0]  sat_fwd_2;
    logic [1:0]  sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard u_dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stall(stall), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
        .stall_count(stall_count)
    );

    hazard_scoreboard #(.CNT_W(2)) u_sat (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stall(sat_stall), .fwd_sel_1(sat_fwd_1), .fwd_sel_2(sat_fwd_2),
        .stall_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic [4:0] d,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = d; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic clear_id();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        clear_id();
        #1;
        arst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        n_checks++; if (fwd_sel_1 !== 3'd0 || fwd_sel_2 !== 3'd0 || sat_fwd_1 !== 3'd0 || sat_fwd_2 !== 3'd0) begin
            n_fail++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_sel_1, fwd_sel_2); end
        tick(); tick();
        n_checks++; if (stall_count !== 32'd0 || sat_count !== 2'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0/0", stall_count, sat_count); end
    endtask

`ifndef HAZARD_SCOREBOARD_FWD_EN
    // add x3 then an immediate consumer: three stalls, never a forward.
    task automatic test_add_stall();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL add_issue_stall: got %0b expected 0", stall); end
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (stall !== (c < 3)) begin n_fail++; $display("FAIL add_stall c%0d: got %0b expected %0b", c, stall, (c < 3)); end
            n_checks++; if (stall_count !== 32'(c)) begin n_fail++; $display("FAIL add_count c%0d: got %0d expected %0d", c, stall_count, c); end
            n_checks++; if (fwd_sel_1 !== 3'd0 || fwd_sel_2 !== 3'd0) begin
                n_fail++; $display("FAIL add_fwd c%0d: got %0d/%0d expected 0/0", c, fwd_sel_1, fwd_sel_2); end
            tick();
        end
        clear_id();
        #1;
        n_checks++; if (stall_count !== 32'd3) begin n_fail++; $display("FAIL add_final_count: got %0d expected 3", stall_count); end
        n_checks++; if (fwd_sel_1 !== 3'd0) begin n_fail++; $display("FAIL add_fwd_tied: got %0d expected 0", fwd_sel_1); end
    endtask

    // Flush overrides the stall; EX/MEM squashed, WB takes the old MEM entry.
    task automatic test_flush();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %0b expected 1", stall); end
        flush = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_wins: got %0b expected 0", stall); end
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_ex_bubble: got %0b expected 0", stall); end
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_wb_kept: got %0b expected 1", stall); end
        set_id(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_old_wb_gone: got %0b expected 0", stall); end
        n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", stall_count); end
        clear_id();
    endtask
`else
    // Back-to-back ALU consumers forward from MEM (1) and WB (2), youngest first.
    task automatic test_forward();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_no_stall: got %0b expected 0", stall); end
        tick(); clear_id(); #1;
        n_checks++; if (fwd_sel_1 !== 3'd1 || fwd_sel_2 !== 3'd0) begin
            n_fail++; $display("FAIL fwd_dist1: got %0d/%0d expected 1/0", fwd_sel_1, fwd_sel_2); end

        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
        clear_id(); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd2_no_stall: got %0b expected 0", stall); end
        tick(); clear_id(); #1;
        n_checks++; if (fwd_sel_1 !== 3'd2) begin n_fail++; $display("FAIL fwd_dist2: got %0d expected 2", fwd_sel_1); end

        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); tick();
        clear_id(); #1;
        n_checks++; if (fwd_sel_1 !== 3'd1 || fwd_sel_2 !== 3'd1) begin
            n_fail++; $display("FAIL fwd_youngest: got %0d/%0d expected 1/1", fwd_sel_1, fwd_sel_2); end
        tick(); #1;
        n_checks++; if (fwd_sel_1 !== 3'd0 || fwd_sel_2 !== 3'd0) begin
            n_fail++; $display("FAIL fwd_bubble_ex: got %0d/%0d expected 0/0", fwd_sel_1, fwd_sel_2); end
    endtask

    // load x7 then consumer: one stall, then forward from WB.
    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_issue: got %0b expected 0", stall); end
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b expected 1", stall); end
        tick(); #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_end: got %0b expected 0", stall); end
        n_checks++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
        tick(); clear_id(); #1;
        n_checks++; if (fwd_sel_2 !== 3'd2 || fwd_sel_1 !== 3'd0) begin
            n_fail++; $display("FAIL lu_fwd: got %0d/%0d expected 0/2", fwd_sel_1, fwd_sel_2); end
        n_checks++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL lu_count_hold: got %0d expected 1", stall_count); end
    endtask

    // Flush during a load-use stall: no stall, and the flushed load never forwards.
    task automatic test_flush();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %0b expected 1", stall); end
        flush = 1'b1; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_wins: got %0b expected 0", stall); end
        tick(); flush = 1'b0; #1;
        n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", stall_count); end
        tick(); clear_id(); #1;
        n_checks++; if (fwd_sel_1 !== 3'd0) begin n_fail++; $display("FAIL flush_squashed_fwd: got %0d expected 0", fwd_sel_1); end
    endtask
`endif

    task automatic test_x0();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %0b expected 0", stall); end
        tick(); clear_id(); #1;
        n_checks++; if (fwd_sel_1 !== 3'd0 || fwd_sel_2 !== 3'd0) begin
            n_fail++; $display("FAIL x0_fwd: got %0d/%0d expected 0/0", fwd_sel_1, fwd_sel_2); end
    endtask

    // Chain of dependent loads; the 2-bit counter saturates at 3.
    task automatic test_saturation();
        int total;
        total = 0;
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1); tick();
        for (int n = 1; n <= LINKS; n++) begin
            set_id(1'b1, 5'(n), 1'b1, 5'd0, 1'b0, 5'(n + 1), 1'b1, 1'b1);
            for (int s = 0; s < STALLS_PER; s++) begin
                #1;
                n_checks++; if (stall !== 1'b1 || sat_stall !== 1'b1) begin
                    n_fail++; $display("FAIL chain_stall n%0d s%0d: got %0b expected 1", n, s, stall); end
                tick();
                total++;
                if (total == 2) begin
                    n_checks++; if (sat_count !== 2'd2) begin n_fail++; $display("FAIL sat_mid: got %0d expected 2", sat_count); end
                end
            end
            #1;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL chain_release n%0d: got %0b expected 0", n, stall); end
            tick();
        end
        clear_id(); #1;
        n_checks++; if (stall_count !== 32'(LINKS * STALLS_PER)) begin
            n_fail++; $display("FAIL chain_count: got %0d expected %0d", stall_count, LINKS * STALLS_PER); end
        n_checks++; if (sat_count !== 2'd3) begin n_fail++; $display("FAIL sat_final: got %0d expected 3", sat_count); end
    endtask

    // Asynchronous reset during a stall clears everything at once, no replay.
    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        for (int s = 0; s < STALLS_PER; s++) tick();
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rms_pre_stall: got %0b expected 1", stall); end
        n_checks++; if (stall_count !== 32'(STALLS_PER)) begin
            n_fail++; $display("FAIL rms_pre_count: got %0d expected %0d", stall_count, STALLS_PER); end
        arst_n = 1'b0; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall: got %0b expected 0", stall); end
        n_checks++; if (stall_count !== 32'd0 || sat_count !== 2'd0) begin
            n_fail++; $display("FAIL rms_count: got %0d/%0d expected 0/0", stall_count, sat_count); end
        arst_n = 1'b1; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_no_replay: got %0b expected 0", stall); end
        tick(); #1;
        n_checks++; if (stall !== 1'b0 || stall_count !== 32'd0) begin
            n_fail++; $display("FAIL rms_after: got %0b/%0d expected 0/0", stall, stall_count); end
        clear_id();
    endtask

    // enable low holds entries and counter; the stall resumes unchanged.
    task automatic test_enable_freeze();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL frz_pre: got %0b expected 1", stall); end
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            n_checks++; if (stall !== 1'b1 || stall_count !== 32'd0) begin
                n_fail++; $display("FAIL frz_hold c%0d: got %0b/%0d expected 1/0", c, stall, stall_count); end
        end
        enable = 1'b1;
        for (int s = 0; s < STALLS_PER; s++) begin
            #1;
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL frz_resume s%0d: got %0b expected 1", s, stall); end
            tick();
            n_checks++; if (stall_count !== 32'(s + 1)) begin
                n_fail++; $display("FAIL frz_count s%0d: got %0d expected %0d", s, stall_count, s + 1); end
        end
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL frz_end: got %0b expected 0", stall); end
        clear_id();
    endtask

    initial begin
        arst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        clear_id();
        #2;
        test_reset();
`ifdef HAZARD_SCOREBOARD_FWD_EN
        test_forward();
        test_load_use();
`else
        test_add_stall();
`endif
        test_flush();
        test_x0();
        test_saturation();
        test_reset_mid_stall();
        test_enable_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
